// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared types and constants for the multi-channel alarm editor.
//   loc_e       : field currently being edited (NONE / SEC / MIN / HR)
//   BCD_MAX_MS  : upper bound of the seconds and minutes fields (59)
//   BCD_ZERO    : lower bound of every field
//   BCD_NIB_MAX : largest legal BCD digit
// ---------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [1:0] {
        LOC_NONE = 2'd0,
        LOC_SEC  = 2'd1,
        LOC_MIN  = 2'd2,
        LOC_HR   = 2'd3
    } loc_e;

    localparam logic [7:0] BCD_MAX_MS  = 8'h59;
    localparam logic [7:0] BCD_ZERO    = 8'h00;
    localparam logic [3:0] BCD_NIB_MAX = 4'h9;

endpackage

// File: rtl/bcd_step.sv
// ---------------------------------------------------------------------------
// bcd_step
// Purely combinational two-digit BCD up/down stepper with wrap.
// Ports:
//   value_in   in  8 : current BCD value
//   max_value  in  8 : BCD maximum; up from max wraps to 00, down from 00
//                      wraps to max
//   up         in  1 : step up by one
//   down       in  1 : step down by one
//   next_value out 8 : stepped value (unchanged when up == down)
// ---------------------------------------------------------------------------
module bcd_step
    import alarm_pkg::*;
(
    input  logic [7:0] value_in,
    input  logic [7:0] max_value,
    input  logic       up,
    input  logic       down,
    output logic [7:0] next_value
);

    always_comb begin
        next_value = value_in;
        if (up && !down) begin
            if (value_in == max_value) begin
                next_value = BCD_ZERO;
            end else if (value_in[3:0] == BCD_NIB_MAX) begin
                next_value = {value_in[7:4] + 4'd1, 4'h0};
            end else begin
                next_value = {value_in[7:4], value_in[3:0] + 4'd1};
            end
        end else if (down && !up) begin
            if (value_in == BCD_ZERO) begin
                next_value = max_value;
            end else if (value_in[3:0] == 4'h0) begin
                next_value = {value_in[7:4] - 4'd1, BCD_NIB_MAX};
            end else begin
                next_value = {value_in[7:4], value_in[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/alarm_bank_set.sv
// ---------------------------------------------------------------------------
// alarm_bank_set
// N_ALARM independent BCD alarm times with per-channel enable, field-wise
// up/down editing of the selected channel and a one-cycle match pulse.
// Optional feature macro: ALARM_SUB_EN (enables decrement via time_sub;
// without it time_sub is ignored and has no delay register).
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   set_mod, set_alarm               : edit mode = set_mod && set_alarm
//   alarm_sel      in SEL_W          : channel edited / displayed
//   time_add, time_sub               : step buttons (level, debounced)
//   set_location, alarm_toggle       : field-advance and enable buttons
//   hr_now, mn_now, sd_now  in 8     : running BCD time
//   hr_alarm, mn_alarm, sd_alarm out : selected channel's stored time
//   alarm_location out 2             : 0 none, 1 sec, 2 min, 3 hr
//   alarm_en       out N_ALARM       : per-channel enable
//   alarm_hit      out N_ALARM       : one-cycle match pulse
// ---------------------------------------------------------------------------
module alarm_bank_set
    import alarm_pkg::*;
#(
    parameter int         N_ALARM = 4,
    parameter int         SEL_W   = 2,
    parameter logic [7:0] HR_MAX  = 8'h23
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_mod,
    input  logic               set_alarm,
    input  logic [SEL_W-1:0]   alarm_sel,
    input  logic               time_add,
    input  logic               time_sub,
    input  logic               set_location,
    input  logic               alarm_toggle,
    input  logic [7:0]         hr_now,
    input  logic [7:0]         mn_now,
    input  logic [7:0]         sd_now,
    output logic [7:0]         hr_alarm,
    output logic [7:0]         mn_alarm,
    output logic [7:0]         sd_alarm,
    output logic [1:0]         alarm_location,
    output logic [N_ALARM-1:0] alarm_en,
    output logic [N_ALARM-1:0] alarm_hit
);

    // Button delay registers (reset to 1 so a held button is not an edge)
    logic add_dly_q, add_dly_d;
    logic loc_dly_q, loc_dly_d;
    logic tog_dly_q, tog_dly_d;
    logic add_edge, sub_edge, loc_edge, tog_edge;

`ifdef ALARM_SUB_EN
    logic sub_dly_q, sub_dly_d;
`else
    logic unused_time_sub;
    assign unused_time_sub = time_sub;
`endif

    logic edit_mode;
    logic sel_valid;
    loc_e loc_q, loc_d;

    logic [7:0] hr_q [N_ALARM];
    logic [7:0] mn_q [N_ALARM];
    logic [7:0] sd_q [N_ALARM];
    logic [7:0] hr_d [N_ALARM];
    logic [7:0] mn_d [N_ALARM];
    logic [7:0] sd_d [N_ALARM];

    logic [N_ALARM-1:0] en_q, en_d;
    logic [N_ALARM-1:0] hist_q, hist_d;
    logic [N_ALARM-1:0] hit_q, hit_d;
    logic [N_ALARM-1:0] match;

    logic [7:0] sel_hr, sel_mn, sel_sd;
    logic [7:0] field_cur, field_max, field_next;
    logic       step_fire;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    always_comb begin
        add_dly_d = time_add;
        loc_dly_d = set_location;
        tog_dly_d = alarm_toggle;
        add_edge  = time_add && !add_dly_q;
        loc_edge  = set_location && !loc_dly_q;
        tog_edge  = alarm_toggle && !tog_dly_q;
`ifdef ALARM_SUB_EN
        sub_dly_d = time_sub;
        sub_edge  = time_sub && !sub_dly_q;
`else
        sub_edge  = 1'b0;
`endif
    end

    assign edit_mode = set_mod && set_alarm;

    // ------------------------------------------------------------------
    // Selected-channel read mux; out-of-range selects read as zero
    // ------------------------------------------------------------------
    always_comb begin
        sel_valid = 1'b0;
        sel_hr    = BCD_ZERO;
        sel_mn    = BCD_ZERO;
        sel_sd    = BCD_ZERO;
        for (int i = 0; i < N_ALARM; i++) begin
            if (alarm_sel == SEL_W'(i)) begin
                sel_valid = 1'b1;
                sel_hr    = hr_q[i];
                sel_mn    = mn_q[i];
                sel_sd    = sd_q[i];
            end
        end
    end

    assign hr_alarm = sel_hr;
    assign mn_alarm = sel_mn;
    assign sd_alarm = sel_sd;

    // ------------------------------------------------------------------
    // Single shared stepper fed by the field under the current location.
    // The old location is used, so a simultaneous set_location edge
    // does not redirect the step.
    // ------------------------------------------------------------------
    always_comb begin
        field_cur = BCD_ZERO;
        field_max = BCD_MAX_MS;
        unique case (loc_q)
            LOC_SEC: field_cur = sel_sd;
            LOC_MIN: field_cur = sel_mn;
            LOC_HR: begin
                field_cur = sel_hr;
                field_max = HR_MAX;
            end
            default: field_cur = BCD_ZERO;
        endcase
    end

    bcd_step u_bcd_step (
        .value_in   (field_cur),
        .max_value  (field_max),
        .up         (add_edge),
        .down       (sub_edge),
        .next_value (field_next)
    );

    // Both edges together cancel, so only an exclusive edge fires a step
    assign step_fire = edit_mode && sel_valid && (loc_q != LOC_NONE)
                       && (add_edge ^ sub_edge);

    // ------------------------------------------------------------------
    // Storage and enable next-state
    // ------------------------------------------------------------------
    always_comb begin
        en_d = en_q;
        for (int i = 0; i < N_ALARM; i++) begin
            hr_d[i] = hr_q[i];
            mn_d[i] = mn_q[i];
            sd_d[i] = sd_q[i];
            if (alarm_sel == SEL_W'(i)) begin
                if (step_fire) begin
                    unique case (loc_q)
                        LOC_SEC: sd_d[i] = field_next;
                        LOC_MIN: mn_d[i] = field_next;
                        LOC_HR:  hr_d[i] = field_next;
                        default: ;
                    endcase
                end
                if (tog_edge && set_mod) begin
                    en_d[i] = ~en_q[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Location FSM: forced to NONE whenever edit mode drops
    // ------------------------------------------------------------------
    always_comb begin
        loc_d = loc_q;
        if (!edit_mode) begin
            loc_d = LOC_NONE;
        end else if (loc_edge) begin
            unique case (loc_q)
                LOC_NONE: loc_d = LOC_SEC;
                LOC_SEC:  loc_d = LOC_MIN;
                LOC_MIN:  loc_d = LOC_HR;
                LOC_HR:   loc_d = LOC_SEC;
                default:  loc_d = LOC_NONE;
            endcase
        end
    end

    assign alarm_location = loc_q;

    // ------------------------------------------------------------------
    // Match detection. History keeps tracking in edit mode so that
    // leaving edit mode on an already-matching time gives no pulse.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_ALARM; gi++) begin : g_match
            assign match[gi] = en_q[gi] && (hr_q[gi] == hr_now)
                               && (mn_q[gi] == mn_now) && (sd_q[gi] == sd_now);
            assign hit_d[gi] = match[gi] && !hist_q[gi] && !edit_mode;
        end
    endgenerate

    assign hist_d    = match;
    assign alarm_en  = en_q;
    assign alarm_hit = hit_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_dly_q <= 1'b1;
            loc_dly_q <= 1'b1;
            tog_dly_q <= 1'b1;
            loc_q     <= LOC_NONE;
            en_q      <= '0;
            hist_q    <= '0;
            hit_q     <= '0;
            for (int i = 0; i < N_ALARM; i++) begin
                hr_q[i] <= BCD_ZERO;
                mn_q[i] <= BCD_ZERO;
                sd_q[i] <= BCD_ZERO;
            end
        end else begin
            add_dly_q <= add_dly_d;
            loc_dly_q <= loc_dly_d;
            tog_dly_q <= tog_dly_d;
            loc_q     <= loc_d;
            en_q      <= en_d;
            hist_q    <= hist_d;
            hit_q     <= hit_d;
            for (int i = 0; i < N_ALARM; i++) begin
                hr_q[i] <= hr_d[i];
                mn_q[i] <= mn_d[i];
                sd_q[i] <= sd_d[i];
            end
        end
    end

`ifdef ALARM_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_dly_q <= 1'b1;
        end else begin
            sub_dly_q <= sub_dly_d;
        end
    end
`endif

endmodule

// File: tb/tb_alarm_bank_set.sv
// ---------------------------------------------------------------------------
// tb_alarm_bank_set
// Directed and random stimulus for alarm_bank_set, checked every cycle
// against a reference model that keeps alarm times as decimal integers and
// steps them with modular arithmetic.
// ---------------------------------------------------------------------------
module tb_alarm_bank_set;

    localparam int         N   = 4;
    localparam int         SW  = 2;
    localparam logic [7:0] HRM = 8'h23;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          set_mod, set_alarm;
    logic [SW-1:0] alarm_sel;
    logic          time_add, time_sub, set_location, alarm_toggle;
    logic [7:0]    hr_now, mn_now, sd_now;
    logic [7:0]    hr_alarm, mn_alarm, sd_alarm;
    logic [1:0]    alarm_location;
    logic [N-1:0]  alarm_en, alarm_hit;

    alarm_bank_set #(.N_ALARM(N), .SEL_W(SW), .HR_MAX(HRM)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_mod        (set_mod),
        .set_alarm      (set_alarm),
        .alarm_sel      (alarm_sel),
        .time_add       (time_add),
        .time_sub       (time_sub),
        .set_location   (set_location),
        .alarm_toggle   (alarm_toggle),
        .hr_now         (hr_now),
        .mn_now         (mn_now),
        .sd_now         (sd_now),
        .hr_alarm       (hr_alarm),
        .mn_alarm       (mn_alarm),
        .sd_alarm       (sd_alarm),
        .alarm_location (alarm_location),
        .alarm_en       (alarm_en),
        .alarm_hit      (alarm_hit)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: times as decimal integers
    int m_h [N];
    int m_m [N];
    int m_s [N];
    bit m_en [N];
    bit m_hist [N];
    bit m_hit [N];
    int m_loc;
    bit p_add, p_sub, p_loc, p_tog;
    int hr_mod;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_h[i] = 0; m_m[i] = 0; m_s[i] = 0;
            m_en[i] = 0; m_hist[i] = 0; m_hit[i] = 0;
        end
        m_loc = 0;
        p_add = 1; p_sub = 1; p_loc = 1; p_tog = 1;
    endtask

    // One rising edge of the model, using the inputs applied this cycle
    task automatic model_clock();
        bit edit, valid, ae, se, le, te;
        bit mt [N];
        int s, d;
        edit  = set_mod && set_alarm;
        s     = int'(alarm_sel);
        valid = (s < N);
        ae    = time_add && !p_add;
`ifdef ALARM_SUB_EN
        se    = time_sub && !p_sub;
`else
        se    = 0;
`endif
        le    = set_location && !p_loc;
        te    = alarm_toggle && !p_tog;
        for (int i = 0; i < N; i++) begin
            mt[i] = m_en[i] && (to_bcd(m_h[i]) == hr_now)
                    && (to_bcd(m_m[i]) == mn_now) && (to_bcd(m_s[i]) == sd_now);
        end
        if (edit && m_loc != 0 && valid && (ae != se)) begin
            d = ae ? 1 : -1;
            case (m_loc)
                1: m_s[s] = (m_s[s] + d + 60) % 60;
                2: m_m[s] = (m_m[s] + d + 60) % 60;
                default: m_h[s] = (m_h[s] + d + hr_mod) % hr_mod;
            endcase
        end
        if (te && set_mod && valid) m_en[s] = !m_en[s];
        if (!edit) m_loc = 0;
        else if (le) m_loc = (m_loc == 3) ? 1 : m_loc + 1;
        for (int i = 0; i < N; i++) begin
            m_hit[i]  = mt[i] && !m_hist[i] && !edit;
            m_hist[i] = mt[i];
        end
        p_add = time_add; p_sub = time_sub; p_loc = set_location; p_tog = alarm_toggle;
    endtask

    task automatic check_all(input string tag);
        int s;
        logic [7:0] eh, em, es;
        logic [N-1:0] een, ehit;
        s  = int'(alarm_sel);
        eh = (s < N) ? to_bcd(m_h[s]) : 8'h00;
        em = (s < N) ? to_bcd(m_m[s]) : 8'h00;
        es = (s < N) ? to_bcd(m_s[s]) : 8'h00;
        for (int i = 0; i < N; i++) begin
            een[i]  = m_en[i];
            ehit[i] = m_hit[i];
        end
        chk({tag, ".hr"}, 32'(hr_alarm), 32'(eh));
        chk({tag, ".mn"}, 32'(mn_alarm), 32'(em));
        chk({tag, ".sd"}, 32'(sd_alarm), 32'(es));
        chk({tag, ".loc"}, 32'(alarm_location), 32'(m_loc));
        chk({tag, ".en"}, 32'(alarm_en), 32'(een));
        chk({tag, ".hit"}, 32'(alarm_hit), 32'(ehit));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic press_add(input int n);
        for (int k = 0; k < n; k++) begin
            time_add = 1; tick("add");
            time_add = 0; tick("add_rel");
        end
    endtask

    task automatic press_loc(input int n);
        for (int k = 0; k < n; k++) begin
            set_location = 1; tick("loc");
            set_location = 0; tick("loc_rel");
        end
    endtask

    task automatic press_tog();
        alarm_toggle = 1; tick("tog");
        alarm_toggle = 0; tick("tog_rel");
    endtask

`ifdef ALARM_SUB_EN
    task automatic press_sub(input int n);
        for (int k = 0; k < n; k++) begin
            time_sub = 1; tick("sub");
            time_sub = 0; tick("sub_rel");
        end
    endtask
`endif

    task automatic set_now(input int h, input int m, input int s);
        hr_now = to_bcd(h); mn_now = to_bcd(m); sd_now = to_bcd(s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_loc [4];
        int c;
        hr_mod = from_bcd(HRM) + 1;
        rst_n = 0; set_mod = 0; set_alarm = 0; alarm_sel = '0;
        time_add = 1; time_sub = 0; set_location = 0; alarm_toggle = 0;
        set_now(11, 11, 11);
        model_reset();
        #12;
        check_all("reset");

        // Release reset with time_add still held: no edge
        @(negedge clk);
        rst_n = 1;
        set_mod = 1; set_alarm = 1; alarm_sel = 2'd2;
        tick("hold");
        press_loc(1);
        tick("held_add");
        chk("held_add_no_step", 32'(sd_alarm), 32'h00);
        time_add = 0; tick("add_release");
        time_add = 1; tick("add_repress");
        chk("repress_step", 32'(sd_alarm), 32'h01);
        time_add = 0; tick("add_release2");

        // Seconds wrap after 60 steps in total
        press_add(59);
        chk("sec_wrap", 32'(sd_alarm), 32'h00);

        // Hour wrap at HR_MAX
        press_loc(2);
        press_add(23);
        chk("hr_max", 32'(hr_alarm), 32'h23);
        press_add(1);
        chk("hr_wrap", 32'(hr_alarm), 32'h00);

        // Other channels untouched; mux has zero latency
        alarm_sel = 2'd0; #1; check_all("sel0");
        chk("ch0_sd", 32'(sd_alarm), 32'h00);
        alarm_sel = 2'd1; #1; check_all("sel1");
        alarm_sel = 2'd3; #1; check_all("sel3");
        alarm_sel = 2'd2; #1;
        chk("ch2_sd_back", 32'(sd_alarm), 32'h00);

`ifdef ALARM_SUB_EN
        press_sub(1);
        chk("hr_sub_wrap", 32'(hr_alarm), 32'h23);
        press_loc(1);
        press_sub(1);
        chk("sec_sub_wrap", 32'(sd_alarm), 32'h59);
        press_loc(1);
        press_add(10);
        press_sub(1);
        chk("min_sub_borrow", 32'(mn_alarm), 32'h09);
        time_add = 1; time_sub = 1; tick("both");
        time_add = 0; time_sub = 0; tick("both_rel");
        chk("add_sub_same", 32'(mn_alarm), 32'h09);
`else
        time_sub = 1;
        press_add(1);
        time_sub = 0;
        chk("add_ignores_sub", 32'(hr_alarm), 32'h01);
`endif

        // Location sequence and forced NONE
        set_alarm = 0; tick("drop");
        chk("loc_drop0", 32'(alarm_location), 32'd0);
        set_alarm = 1;
        exp_loc = '{1, 2, 3, 1};
        for (int k = 0; k < 4; k++) begin
            set_location = 1; tick("loc_seq");
            chk("loc_seq", 32'(alarm_location), 32'(exp_loc[k]));
            set_location = 0; tick("loc_seq_rel");
        end
        set_alarm = 0; tick("drop2");
        chk("loc_drop", 32'(alarm_location), 32'd0);

        // ch1 = 07:30:00, enabled, then match
        alarm_sel = 2'd1; set_alarm = 1;
        tick("enter");
        press_loc(2);
        press_add(30);
        press_loc(1);
        press_add(7);
        press_tog();
        chk("ch1_en", 32'(alarm_en[1]), 32'd1);
        set_alarm = 0;
        set_now(7, 29, 59); tick("pre_match");
        chk("no_hit_early", 32'(alarm_hit), 32'd0);
        set_now(7, 30, 0); tick("match");
        chk("hit_pulse", 32'(alarm_hit), 32'b0010);
        tick("match_hold");
        chk("hit_one_cycle", 32'(alarm_hit), 32'd0);
        press_tog();
        chk("ch1_dis", 32'(alarm_en[1]), 32'd0);
        set_now(7, 29, 59); tick("pre_match2");
        set_now(7, 30, 0); tick("match2");
        chk("disabled_no_hit", 32'(alarm_hit), 32'd0);

        // ch3 = 12:34:56 enabled, location MIN, then async reset
        alarm_sel = 2'd3; set_alarm = 1;
        tick("enter3");
        press_loc(1); press_add(56);
        press_loc(1); press_add(34);
        press_loc(1); press_add(12);
        press_tog();
        press_loc(2);
        set_now(12, 34, 56); tick("edit_match");
        chk("ch3_loc", 32'(alarm_location), 32'd2);
        chk("ch3_hr", 32'(hr_alarm), 32'h12);
        chk("edit_no_hit", 32'(alarm_hit), 32'd0);
        time_add = 1;
        #2 rst_n = 0;
        model_reset();
        #1 check_all("async_rst");
        chk("rst_sd", 32'(sd_alarm), 32'h00);
        time_add = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1; set_alarm = 0;
        tick("post_rst");
        tick("post_rst2");
        chk("no_spurious_hit", 32'(alarm_hit), 32'd0);

        // Random phase
        for (int k = 0; k < 600; k++) begin
            set_mod      = ($urandom_range(0, 7) != 0);
            set_alarm    = ($urandom_range(0, 3) != 0);
            alarm_sel    = SW'($urandom_range(0, N - 1));
            time_add     = $urandom_range(0, 1) != 0;
            time_sub     = $urandom_range(0, 1) != 0;
            set_location = $urandom_range(0, 3) == 0;
            alarm_toggle = $urandom_range(0, 5) == 0;
            if ($urandom_range(0, 1) != 0) begin
                c = int'($urandom_range(0, N - 1));
                set_now(m_h[c], m_m[c], m_s[c]);
            end else begin
                set_now(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                        int'($urandom_range(0, 59)));
            end
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
